// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA input scheduler.
// Contents: scan FSM state enum, idle (released) bus values and bus bit indices.
package jamma_pkg;

  typedef enum logic [2:0] {
    StSettleP1,
    StSampleP1,
    StSettleP2,
    StSampleP2,
    StIdle
  } state_e;

  // All inputs are active-low, so "nothing pressed" is all ones.
  localparam logic [7:0] JOY_IDLE  = 8'hFF;
  localparam logic [1:0] COIN_IDLE = 2'b11;

  // Bus layout: [7]=start, [6]=aux (passed through), [5:0]=fire2,fire1,R,L,D,U.
  localparam int unsigned JOY_BIT_START = 7;
  localparam int unsigned JOY_BIT_AUX   = 6;
  localparam int unsigned JOY_CTRL_W    = 6;

endpackage

// File: rtl/jamma_debounce.sv
// Sample-enabled vector debouncer.
// A candidate value must be seen on DB_SAMPLES consecutive enabled samples before
// the stable output takes it; any differing sample restarts the count at 1.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   sample_en   qualifies data for one cycle
//   data        W-bit sample
//   stable      debounced vector, resets to IDLE
module jamma_debounce #(
  parameter int unsigned   W          = 8,
  parameter int unsigned   DB_SAMPLES = 4,
  parameter logic [W-1:0]  IDLE       = '1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         sample_en,
  input  logic [W-1:0] data,
  output logic [W-1:0] stable
);

  localparam logic [3:0] CntMax = 4'(DB_SAMPLES);

  logic [W-1:0] cand_q, cand_d;
  logic [W-1:0] stable_q, stable_d;
  logic [3:0]   cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sample_en) begin
      if (data == cand_q) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = data;
        cnt_d  = 4'd1;
      end
      // Commit only once the full run of matching samples has been seen.
      if (cnt_d == CntMax) stable_d = data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_q   <= IDLE;
      cnt_q    <= 4'd0;
      stable_q <= IDLE;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/jamma_input_scheduler.sv
// JAMMA input scheduler: time-multiplexes the shared 8-bit bus between players
// via JSELECT, waits SETTLE_CYC cycles after each select change, samples, and
// debounces both player vectors plus the synchronised coin inputs.
// Optional feature macro: KBD_OVERLAY_EN (adds KB_JOY, ANDed into JOY1[5:0]).
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   JJOY        shared bus, active-low
//   JCOIN       coin switches, active-low, asynchronous
//   KB_JOY      keyboard P1 controls, active-low (KBD_OVERLAY_EN only)
//   JSELECT     0 = player 1, 1 = player 2
//   JOY1, JOY2  debounced player vectors
//   COIN        debounced coin vector
//   SCAN_DONE   one-cycle pulse at the end of each P1+P2 scan
module jamma_input_scheduler
  import jamma_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned DB_SAMPLES = 4,
  parameter int unsigned SAMPLE_DIV = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] JJOY,
  input  logic [1:0] JCOIN,
`ifdef KBD_OVERLAY_EN
  input  logic [5:0] KB_JOY,
`endif
  output logic       JSELECT,
  output logic [7:0] JOY1,
  output logic [7:0] JOY2,
  output logic [1:0] COIN,
  output logic       SCAN_DONE
);

  localparam int unsigned CntW = 16;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            jsel_q, jsel_d;
  logic [1:0]      coin_meta_q, coin_sync_q;
  logic [7:0]      p1_db, p2_db;
  logic            p1_en, p2_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jsel_d  = jsel_q;
    unique case (state_q)
      StSettleP1: begin
        if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
          state_d = StSampleP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSampleP1: begin
        jsel_d  = 1'b1;
        cnt_d   = '0;
        state_d = StSettleP2;
      end
      StSettleP2: begin
        if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
          state_d = StSampleP2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSampleP2: begin
        jsel_d  = 1'b0;
        cnt_d   = '0;
        state_d = (SAMPLE_DIV > 0) ? StIdle : StSettleP1;
      end
      StIdle: begin
        if (cnt_q == CntW'(SAMPLE_DIV - 1)) begin
          state_d = StSettleP1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StSettleP1;
        cnt_d   = '0;
        jsel_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StSettleP1;
      cnt_q       <= '0;
      jsel_q      <= 1'b0;
      coin_meta_q <= COIN_IDLE;
      coin_sync_q <= COIN_IDLE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jsel_q      <= jsel_d;
      coin_meta_q <= JCOIN;
      coin_sync_q <= coin_meta_q;
    end
  end

  // Sampling happens a full settle window after the registered select changed.
  assign p1_en     = (state_q == StSampleP1);
  assign p2_en     = (state_q == StSampleP2);
  assign SCAN_DONE = p2_en;
  assign JSELECT   = jsel_q;

  jamma_debounce #(.W(8), .DB_SAMPLES(DB_SAMPLES), .IDLE(JOY_IDLE)) u_db_p1 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .sample_en (p1_en),
    .data      (JJOY),
    .stable    (p1_db)
  );

  jamma_debounce #(.W(8), .DB_SAMPLES(DB_SAMPLES), .IDLE(JOY_IDLE)) u_db_p2 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .sample_en (p2_en),
    .data      (JJOY),
    .stable    (p2_db)
  );

  // Coins are sampled once per scan so their timing does not depend on JSELECT.
  jamma_debounce #(.W(2), .DB_SAMPLES(DB_SAMPLES), .IDLE(COIN_IDLE)) u_db_coin (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .sample_en (SCAN_DONE),
    .data      (coin_sync_q),
    .stable    (COIN)
  );

`ifdef KBD_OVERLAY_EN
  // Keyboard path is deliberately undebounced; only direction/fire bits overlay.
  assign JOY1 = {p1_db[JOY_BIT_START], p1_db[JOY_BIT_AUX], p1_db[JOY_CTRL_W-1:0] & KB_JOY};
`else
  assign JOY1 = {p1_db[JOY_BIT_START], p1_db[JOY_BIT_AUX], p1_db[JOY_CTRL_W-1:0]};
`endif
  assign JOY2 = p2_db;

endmodule

// File: tb/tb_jamma_input_scheduler.sv
module tb_jamma_input_scheduler;

  logic       CLK;
  logic       RST_N;
  logic [7:0] JJOY;
  logic [1:0] JCOIN;
  logic       JSELECT;
  logic [7:0] JOY1;
  logic [7:0] JOY2;
  logic [1:0] COIN;
  logic       SCAN_DONE;
`ifdef KBD_OVERLAY_EN
  logic [5:0] kb_joy;
`endif

  // Board model: each player's controls appear on the bus when selected.
  logic [7:0] p1_val;
  logic [7:0] p2_val;
  assign JJOY = JSELECT ? p2_val : p1_val;

  int n_cmp;
  int n_bad;
  int cyc;

  jamma_input_scheduler dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .JJOY      (JJOY),
    .JCOIN     (JCOIN),
`ifdef KBD_OVERLAY_EN
    .KB_JOY    (kb_joy),
`endif
    .JSELECT   (JSELECT),
    .JOY1      (JOY1),
    .JOY2      (JOY2),
    .COIN      (COIN),
    .SCAN_DONE (SCAN_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle; sample point sits 1 ns after the falling edge.
  task automatic step();
    @(negedge CLK);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    cyc = 0;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    RST_N  = 1'b0;
    JCOIN  = 2'b11;
    p1_val = 8'hFF;
    p2_val = 8'hFF;
`ifdef KBD_OVERLAY_EN
    kb_joy = 6'h3F;
`endif
    repeat (3) @(negedge CLK);
    #1;
    check_eq("rst_jselect", {31'd0, JSELECT}, 32'd0);
    check_eq("rst_joy1", {24'd0, JOY1}, 32'hFF);
    check_eq("rst_joy2", {24'd0, JOY2}, 32'hFF);
    check_eq("rst_coin", {30'd0, COIN}, 32'h3);
    check_eq("rst_scan_done", {31'd0, SCAN_DONE}, 32'd0);

    // Two idle scans: select low 9 cycles then high 9, pulse on cycle 17 of 18.
    release_reset();
    for (int c = 0; c < 36; c++) begin
      check_eq("scan_jselect", {31'd0, JSELECT}, {31'd0, (c % 18) >= 9});
      check_eq("scan_done", {31'd0, SCAN_DONE}, {31'd0, (c % 18) == 17});
      step();
    end
    check_eq("idle_joy1", {24'd0, JOY1}, 32'hFF);
    check_eq("idle_joy2", {24'd0, JOY2}, 32'hFF);

    // P1 presses up from scan 2; P1 samples at cycles 44,62,80,98.
    p1_val = 8'hFE;
    goto(98);
    check_eq("p1_partial", {24'd0, JOY1}, 32'hFF);
    step();
    check_eq("p1_commit", {24'd0, JOY1}, 32'hFE);
    check_eq("p1_joy2_quiet", {24'd0, JOY2}, 32'hFF);

    // P2 toggles every scan (scans 6..11): never commits.
    for (int s = 6; s < 12; s++) begin
      goto(s * 18);
      p2_val = (s % 2 == 0) ? 8'hDF : 8'hFF;
      check_eq("p2_glitch_hold", {24'd0, JOY2}, 32'hFF);
    end
    // Then steady from scan 12; P2 samples at 233,251,269,287.
    goto(216);
    p2_val = 8'hDF;
    goto(287);
    check_eq("p2_partial", {24'd0, JOY2}, 32'hFF);
    step();
    check_eq("p2_commit", {24'd0, JOY2}, 32'hDF);
    check_eq("p2_joy1_hold", {24'd0, JOY1}, 32'hFE);

    // Coin 0 pressed off-edge at cycle 300; scan-done samples at 305,323,341,359.
    goto(300);
    #2 JCOIN = 2'b10;
    goto(359);
    check_eq("coin_partial", {30'd0, COIN}, 32'h3);
    step();
    check_eq("coin_press", {30'd0, COIN}, 32'h2);
    // Release after 5 scans; samples at 395,413,431,449.
    goto(390);
    #2 JCOIN = 2'b11;
    goto(449);
    check_eq("coin_hold", {30'd0, COIN}, 32'h2);
    step();
    check_eq("coin_release", {30'd0, COIN}, 32'h3);

    // Reset in the middle of SETTLE_P2 with JOY1 latched.
    goto(460);
    check_eq("pre_rst_jselect", {31'd0, JSELECT}, 32'd1);
    check_eq("pre_rst_joy1", {24'd0, JOY1}, 32'hFE);
    #2 RST_N = 1'b0;
    #1;
    check_eq("mid_rst_jselect", {31'd0, JSELECT}, 32'd0);
    check_eq("mid_rst_joy1", {24'd0, JOY1}, 32'hFF);
    check_eq("mid_rst_joy2", {24'd0, JOY2}, 32'hFF);
    check_eq("mid_rst_coin", {30'd0, COIN}, 32'h3);
    check_eq("mid_rst_scan_done", {31'd0, SCAN_DONE}, 32'd0);
    release_reset();
    for (int c = 0; c < 10; c++) begin
      check_eq("post_rst_jselect", {31'd0, JSELECT}, {31'd0, c >= 9});
      step();
    end
    // Debounce restarted: P1 samples at 8,26,44,62.
    goto(62);
    check_eq("post_rst_p1_partial", {24'd0, JOY1}, 32'hFF);
    step();
    check_eq("post_rst_p1_commit", {24'd0, JOY1}, 32'hFE);

`ifdef KBD_OVERLAY_EN
    kb_joy = 6'b111011;
    #1;
    check_eq("kbd_overlay", {24'd0, JOY1}, 32'hFA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jamma_input_scheduler.md
Name: jamma_input_scheduler

Overview:
- Time-multiplexes the shared 8-bit JAMMA input bus between player 1 and player 2 by driving JSELECT.
- Waits a programmable settle time after each select change, then samples the bus.
- Debounces each player vector and the coin inputs, then presents stable active-low vectors to the arcade core.
- Replaces the free-running toggle-every-clock splitter in each arcade top level.

Parameters:
- SETTLE_CYC, 8: CLK cycles after a JSELECT change before the bus is sampled; legal range 1..255.
- DB_SAMPLES, 4: consecutive identical samples required before an output vector updates; legal range 1..15.
- SAMPLE_DIV, 0: extra idle cycles inserted after SAMPLE_P2, giving a coarser scan rate; 0 means none.

Ports:
- CLK  in  1  system/pixel clock.
- RST_N  in  1  asynchronous active-low reset.
- JJOY  in  8  shared JAMMA bus, active-low; [7]=start, [5:0]=fire2,fire1,R,L,D,U.
- JCOIN  in  2  coin switches, active-low, asynchronous to CLK.
- KB_JOY  in  6  keyboard-derived player-1 controls, active-low; present only with the optional feature.
- JSELECT  out  1  bus select; 0 selects player 1, 1 selects player 2.
- JOY1  out  8  debounced player-1 vector.
- JOY2  out  8  debounced player-2 vector.
- COIN  out  2  debounced coin vector.
- SCAN_DONE  out  1  one-cycle pulse when a full P1+P2 scan completes.

Behaviour:
- Clock and reset: one clock domain (CLK). RST_N is asynchronous, active-low.
- Reset values: JSELECT=0; JOY1=8'hFF; JOY2=8'hFF; COIN=2'b11; SCAN_DONE=0; state=SETTLE_P1; settle counter=0; debounce counters=0.
- FSM:
  - SETTLE_P1: JSELECT=0. Counter increments each cycle; when it reaches SETTLE_CYC-1, go to SAMPLE_P1.
  - SAMPLE_P1: JJOY is captured into the P1 debouncer (one cycle). Set JSELECT=1, clear counter, go to SETTLE_P2.
  - SETTLE_P2 / SAMPLE_P2: mirror of the P1 states. SAMPLE_P2 sets JSELECT=0 and asserts SCAN_DONE for that cycle, then goes to IDLE if SAMPLE_DIV>0, else to SETTLE_P1.
  - IDLE: counts SAMPLE_DIV cycles, then goes to SETTLE_P1.
- Scan period = 2*(SETTLE_CYC+1)+SAMPLE_DIV cycles. With defaults this is 18 cycles.
- JSELECT changes only on the clock edge that leaves a SAMPLE state, and it is registered. The bus is never sampled in the same cycle the select changes.
- Player debounce (per vector):
  - Input is a sample-enable plus an 8-bit sample.
  - If the sample equals the held candidate, increment the count, saturating at DB_SAMPLES.
  - Otherwise load the new candidate and set count=1.
  - The output updates on the sample where the count reaches DB_SAMPLES. It never updates on a partial match.
- Coin path:
  - JCOIN passes through a 2-flop synchronizer, then into a debouncer.
  - This debouncer is sample-enabled once per scan, on the SCAN_DONE cycle, so its timing is independent of JSELECT.
- Latency from a stable bus change to the output: at most DB_SAMPLES scans plus 1 cycle.
- Glitch rule: a bus value that flips between scans resets that player's debounce count. The output holds its previous value.
- Reset mid-scan: everything returns immediately to reset values, and the next scan starts at SETTLE_P1.
- Bus bits [6] of JOY1/JOY2 pass through debounced. Their meaning is not defined here.

Optional Feature:
- Macro: KBD_OVERLAY_EN.
- Defined: the KB_JOY port exists. JOY1[5:0] = debounced_P1[5:0] & KB_JOY. The AND is combinational after the debouncer; the keyboard path is not debounced. JOY1[7:6] is unaffected.
- Undefined: the KB_JOY port is absent and JOY1 is the debounced bus only.

Decomposition:
- Package jamma_pkg:
  - state enum (SETTLE_P1, SAMPLE_P1, SETTLE_P2, SAMPLE_P2, IDLE);
  - JOY_IDLE = 8'hFF;
  - COIN_IDLE = 2'b11;
  - bus bit-index constants.
- Sub-module jamma_debounce: parameters W and DB_SAMPLES; inputs CLK, RST_N, sample enable, data; output stable vector, reset to all ones. Instantiated three times: P1 (W=8), P2 (W=8), coin (W=2).

Test Plan:
- Reset release with JJOY=8'hFF: JSELECT toggles, giving JSELECT=1 for 9 cycles and 0 for 9 cycles. SCAN_DONE pulses every 18 cycles. JOY1=JOY2=8'hFF throughout.
- Drive JJOY=8'hFE only while JSELECT=0 (P1 up), default parameters: JOY1 becomes 8'hFE after the 4th P1 sample, then 1 cycle. JOY2 stays 8'hFF.
- P2 value alternates 8'hDF / 8'hFF on successive scans: JOY2 stays 8'hFF indefinitely.
- JCOIN[0] held low for 5 scans, asynchronous to CLK: COIN=2'b10 within 4 scans plus 3 cycles. Release it, and COIN returns to 2'b11 after 4 scans.
- Assert RST_N=0 during SETTLE_P2 with JOY1=8'hFE latched: outputs return to reset values immediately. After release, the first sample is P1 at cycle 9.
- With KBD_OVERLAY_EN defined, KB_JOY=6'b111011 and JJOY=8'hFF: JOY1=8'hFB with no debounce delay.
